// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// byte-enable constants and the address legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam int         WORD_BYTES = 4;

  // Misaligned, or any address bit above the word index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int idx_w);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word storage with one byte-enabled write port and one asynchronous read port.
// Contents are not reset here; the responder clears them through the write port.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [31:0]           wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: clears the array after reset, then serves one
// load/store at a time with WAIT_CYCLES wait states and a held response.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   INIT  | zeroing word[init_cnt], one word per cycle
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | request latched, counting down wait states
//   RESP  | response held until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [IDX_W-1:0] init_cnt;
  logic [3:0]       wait_cnt;

  logic             lat_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_be;

  logic             c_write;
  logic [31:0]      c_addr;
  logic [31:0]      c_wdata;
  logic [3:0]       c_be;
  logic             c_err;
  logic             commit;
  logic [31:0]      rd_next;

  logic             arr_we;
  logic [IDX_W-1:0] arr_waddr;
  logic [3:0]       arr_be;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;

  assign req_ready = (state == IDLE) && !reset;

  // With no wait states the commit happens on the accept edge, so the
  // request is taken straight from the inputs rather than the latch.
  assign c_write = (state == IDLE) ? req_write : lat_write;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign c_be    = (state == IDLE) ? req_be    : lat_be;
  assign c_err   = addr_err(c_addr, IDX_W);

  assign commit = !reset &&
                  (((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (wait_cnt == 4'd0)));

  assign rd_next = (c_err || c_write) ? 32'd0 : arr_rdata;

  assign arr_we    = !reset && ((state == INIT) || (commit && c_write && !c_err));
  assign arr_waddr = (state == INIT) ? init_cnt : c_addr[IDX_W+1:2];
  assign arr_be    = (state == INIT) ? BE_ALL : c_be;
  assign arr_wdata = (state == INIT) ? 32'd0 : c_wdata;

  dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .we    (arr_we),
    .waddr (arr_waddr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .raddr (c_addr[IDX_W+1:2]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == LAST_IDX) state <= IDLE;
          else                      init_cnt <= init_cnt + 1'b1;
        end
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_next;
              rsp_err   <= c_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_next;
            rsp_err   <= c_err;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder: a 256-word,
// 2-wait-state instance plus a 16-word, zero-wait-state instance.
module tb_data_mem_responder;

  localparam int WAIT = 2;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_reset;
  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_z (
    .clock(clock), .reset(z_reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  // Counts cycles from the current sample point until req_ready rises.
  task automatic count_init(input string name, input int exp_len);
    int cnt;
    cnt = 0;
    while (!req_ready && cnt < 1000) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk(name, 32'(cnt), 32'(exp_len));
  endtask

  // Latency counts the accept cycle as 1 and is checked against 1+WAIT.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int k;
    int lat;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    k = 0;
    while (!req_ready && k < 1000) begin
      @(posedge clock); #1;
      k++;
    end
    if (!req_ready) begin
      timeout_fail({tag, "_accept"});
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
    rsp_ready = (hold == 0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!rsp_valid) begin
      timeout_fail({tag, "_rsp"});
      rsp_ready = 1'b0;
      return;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(1 + WAIT));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_post_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_post_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Zero-wait instance: response must be visible right after the accept edge.
  task automatic z_txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
    z_req_valid = 1'b1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wdata; z_req_be = be;
    chk({tag, "_ready"}, 32'(z_req_ready), 32'd1);
    @(posedge clock); #1;
    z_req_valid = 1'b0; z_req_addr = ~addr; z_req_wdata = ~wdata; z_req_be = ~be;
    chk({tag, "_valid"}, 32'(z_rsp_valid), 32'd1);
    chk({tag, "_rdata"}, z_rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(z_rsp_err), 32'(exp_err));
    chk({tag, "_not_ready"}, 32'(z_req_ready), 32'd0);
    z_rsp_ready = 1'b1;
    @(posedge clock); #1;
    z_rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(z_rsp_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(z_req_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,          4'b0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'hDE22_BE44, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0022, 32'h0,          4'b0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0400, 32'h0,          4'b0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'hDE22_BE44, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,          4'b0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_03FC, 32'hA5A5_0F0F, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,          4'b0000, 32'hA5A5_0F0F, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0024, 32'h0,          4'b0000, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_0000, 32'h0,          4'b0000, 32'h0000_0000, 1'b1};

    reset = 1'b1; z_reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'd0;
    z_rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Request held during INIT must not be accepted until clearing finishes.
    reset = 1'b0; z_reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    count_init("init_len", 256);

    for (int i = 0; i < 16; i++) begin
      do_req($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].exp_rd, vecs[i].exp_err, 0);
    end

    do_req("hold_load", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0, 5);
    do_req("hold_err", 1'b0, 32'h0000_0021, 32'h0, 4'b0000, 32'h0000_0000, 1'b1, 5);

    // Reset lands on the edge that would have committed the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0030;
    req_wdata = 32'h55AA_55AA; req_be = 4'b1111;
    chk("rw_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd0);
    chk("rw_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    count_init("reinit_len", 256);
    do_req("rw_load30", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h0000_0000, 1'b0, 0);
    do_req("rw_load20", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0000_0000, 1'b0, 0);
    do_req("rw_raw_st", 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'b1111, 32'h0000_0000, 1'b0, 0);
    do_req("rw_raw_ld", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0, 0);

    z_txn("z_ld4", 1'b0, 32'h0000_0004, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    z_txn("z_st8", 1'b1, 32'h0000_0008, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0);
    z_txn("z_ld8", 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);
    z_txn("z_st8b", 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b1000, 32'h0000_0000, 1'b0);
    z_txn("z_ld8b", 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 32'hAA34_5678, 1'b0);
    z_txn("z_st40", 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1);
    z_txn("z_ld40", 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 32'h0000_0000, 1'b1);
    z_txn("z_ld0", 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
